alu_arbiter: RTL and testbench

- Sequencer and arbiter that shares one combinational ALU datapath between two requesters.
- Each requester presents an opcode and packed operands {A,B} under a valid/ready handshake.
- The block grants one requester at a time (round-robin) and drives the ALU's enable, control and operand bus for one cycle.
- It registers the ALU's {B,C} output and returns it with the requester ID through a response valid/ready handshake.
- It sits between the control front-end (e.g. per-frame VSYNC-driven logic) and the ALU instance.

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one combinational ALU between
// two requesters, with a registered response path.
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   req0_*/req1_*              valid/ready request: op (3b), operands {A,B}
//   alu_en_o/ctl_o/ab_o        ALU drive, active only during ISSUE
//   alu_bc_i                   ALU result {B,C}
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_id_o/rsp_c_o/rsp_b_o   response owner, result C, echoed B
//   busy_o                     high whenever not IDLE
//   op_cnt_o                   completed-response counter (wraps)

module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [2:0]         req0_op_i,
    input  logic [2*WIDTH-1:0] req0_ab_i,

    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [2:0]         req1_op_i,
    input  logic [2*WIDTH-1:0] req1_ab_i,

    output logic               alu_en_o,
    output logic [2:0]         alu_ctl_o,
    output logic [2*WIDTH-1:0] alu_ab_o,
    input  logic [2*WIDTH-1:0] alu_bc_i,

    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [WIDTH-1:0]   rsp_c_o,
    output logic [WIDTH-1:0]   rsp_b_o,

    output logic               busy_o,
    output logic [7:0]         op_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last;
    logic               r_id;
    logic [2:0]         r_op;
    logic [2*WIDTH-1:0] r_ab;
    logic [WIDTH-1:0]   r_c;
    logic [WIDTH-1:0]   r_b;
    logic [7:0]         r_cnt;

    logic               w_idle;
    logic               w_issue;
    logic               w_resp;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_accept;

    assign w_idle  = (r_state == IDLE);
    assign w_issue = (r_state == ISSUE);
    assign w_resp  = (r_state == RESP);

    // Contention goes to whoever was not served last; r_last resets
    // to 1 so requester 0 wins the first contest after reset.
    assign w_grant0 = req0_valid_i & (~req1_valid_i | r_last);
    assign w_grant1 = req1_valid_i & (~req0_valid_i | ~r_last);

    assign w_ready0 = w_idle & w_grant0;
    assign w_ready1 = w_idle & w_grant1;
    assign w_accept = w_ready0 | w_ready1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_op    <= '0;
            r_ab    <= '0;
            r_c     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_ready1 ? req1_op_i : req0_op_i;
                        r_ab    <= w_ready1 ? req1_ab_i : req0_ab_i;
                        r_id    <= w_ready1;
                        r_last  <= w_ready1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_c     <= alu_bc_i[WIDTH-1:0];
                    r_b     <= alu_bc_i[2*WIDTH-1:WIDTH];
                    r_state <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready_o = w_ready0;
    assign req1_ready_o = w_ready1;

    // The ALU bus is quiet outside ISSUE so the shared ALU sees no
    // stale operands while the response waits.
    assign alu_en_o  = w_issue;
    assign alu_ctl_o = w_issue ? r_op : 3'd0;
    assign alu_ab_o  = w_issue ? r_ab : '0;

    assign rsp_valid_o = w_resp;
    assign rsp_id_o    = r_id;
    assign rsp_c_o     = r_c;
    assign rsp_b_o     = r_b;

    assign busy_o   = ~w_idle;
    assign op_cnt_o = r_cnt;

    a_ready_excl: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(req0_ready_o && req1_ready_o)
    );

    a_issue_once: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        alu_en_o |=> !alu_en_o
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU.
// Ports: none (top-level bench).

module tb_alu_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req0_valid = 1'b0;
    logic           req0_ready;
    logic [2:0]     req0_op = '0;
    logic [2*W-1:0] req0_ab = '0;
    logic           req1_valid = 1'b0;
    logic           req1_ready;
    logic [2:0]     req1_op = '0;
    logic [2*W-1:0] req1_ab = '0;
    logic           alu_en;
    logic [2:0]     alu_ctl;
    logic [2*W-1:0] alu_ab;
    logic [2*W-1:0] alu_bc;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic           rsp_id;
    logic [W-1:0]   rsp_c;
    logic [W-1:0]   rsp_b;
    logic           busy;
    logic [7:0]     op_cnt;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_ab_i    (req0_ab),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_ab_i    (req1_ab),
        .alu_en_o     (alu_en),
        .alu_ctl_o    (alu_ctl),
        .alu_ab_o     (alu_ab),
        .alu_bc_i     (alu_bc),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_c_o      (rsp_c),
        .rsp_b_o      (rsp_b),
        .busy_o       (busy),
        .op_cnt_o     (op_cnt)
    );

    // Behavioural ALU: 100 add, 101 sub (wraps), 001 set-less-than.
    function automatic logic [W-1:0] alu_f(
        input logic [2:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        case (op)
            3'b000:  return a;
            3'b001:  return (a < b) ? W'(1) : W'(0);
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a + b;
            3'b101:  return a - b;
            3'b110:  return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_bc = {alu_ab[W-1:0],
                     alu_f(alu_ctl, alu_ab[2*W-1:W], alu_ab[W-1:0])};

    typedef struct packed {
        logic         id;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } exp_t;

    exp_t           sb[$];
    logic           gseq[$];
    int             n_chk = 0;
    int             n_fail = 0;
    int             gcnt = 0;
    int             rcnt = 0;
    logic [2:0]     last_op = '0;
    logic [2*W-1:0] last_ab = '0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge rst_n) sb.delete();

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            check("rdy_excl", 32'(req0_ready & req1_ready), 0);
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, req0_ab[W-1:0],
                              alu_f(req0_op, req0_ab[2*W-1:W], req0_ab[W-1:0])});
                gseq.push_back(1'b0);
                gcnt++;
                last_op = req0_op;
                last_ab = req0_ab;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, req1_ab[W-1:0],
                              alu_f(req1_op, req1_ab[2*W-1:W], req1_ab[W-1:0])});
                gseq.push_back(1'b1);
                gcnt++;
                last_op = req1_op;
                last_ab = req1_ab;
            end
            if (alu_en) begin
                check("alu_ctl", 32'(alu_ctl), 32'(last_op));
                check("alu_ab", 32'(alu_ab), 32'(last_ab));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_b", 32'(rsp_b), 32'(e.b));
                    check("rsp_c", 32'(rsp_c), 32'(e.c));
                end
                rcnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ctl"}, 32'({rsp_valid, rsp_id, alu_en, busy,
                                  req0_ready, req1_ready, alu_ctl}), 0);
        check({tag, "_ab"}, 32'(alu_ab), 0);
        check({tag, "_cb"}, 32'({rsp_c, rsp_b}), 0);
        check({tag, "_cnt"}, 32'(op_cnt), 0);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic run_one(input logic id, input logic [2:0] op,
                           input logic [2*W-1:0] ab,
                           input logic [W-1:0] eb, input logic [W-1:0] ec);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_ab = ab;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_ab = ab;
        end
        mid();
        check("one_rdy", 32'({req1_ready, req0_ready}), id ? 2 : 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        mid();
        check("one_iss", 32'({alu_en, rsp_valid, busy}), 3'b101);
        check("one_ctl", 32'(alu_ctl), 32'(op));
        check("one_ab", 32'(alu_ab), 32'(ab));
        tick();
        mid();
        check("one_rsp", 32'({rsp_valid, rsp_id, alu_en}), {1'b1, id, 1'b0});
        check("one_c", 32'(rsp_c), 32'(ec));
        check("one_b", 32'(rsp_b), 32'(eb));
        tick();
        mid();
        check("one_done", 32'({rsp_valid, busy}), 0);
        tick();
    endtask

    initial begin
        int g0;
        int r0;
        int k;

        repeat (2) tick();
        mid();
        chk_zero("rst");
        tick();
        rst_n = 1'b1;
        tick();
        mid();
        chk_zero("post_rst");
        tick();

        run_one(1'b0, 3'b100, 16'h1234, 8'h34, 8'h46);
        check("cnt_t1", 32'(op_cnt), 1);
        run_one(1'b1, 3'b101, 16'h1020, 8'h20, 8'hF0);
        check("cnt_t2", 32'(op_cnt), 2);

        g0 = gcnt;
        req0_op = 3'b100; req0_ab = 16'h0102; req0_valid = 1'b1;
        req1_op = 3'b101; req1_ab = 16'h0503; req1_valid = 1'b1;
        k = 0;
        while (gcnt < g0 + 4 && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_to", 32'(gcnt >= g0 + 4), 1);
        for (int i = 0; i < 4; i++)
            if (gseq.size() > g0 + i)
                check("rr_order", 32'(gseq[g0+i]), i % 2);
        wait_idle("rr");
        check("cnt_rr", 32'(op_cnt), 6);

        rsp_ready = 1'b0;
        req0_op = 3'b000; req0_ab = 16'h7711; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_op = 3'b110; req1_ab = 16'h0F0F; req1_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            mid();
            check("bp_flags", 32'({rsp_valid, rsp_id, busy, alu_en,
                                   req0_ready, req1_ready}), 6'b101000);
            check("bp_cb", 32'({rsp_c, rsp_b}), 16'h7711);
            check("bp_cnt", 32'(op_cnt), 6);
            tick();
        end
        rsp_ready = 1'b1;
        mid();
        tick();
        check("bp_cnt_rel", 32'(op_cnt), 7);
        mid();
        check("bp_next", 32'({req1_ready, req0_ready}), 2);
        tick();
        req1_valid = 1'b0;
        wait_idle("bp");
        check("bp_cnt_end", 32'(op_cnt), 8);

        req0_op = 3'b100; req0_ab = 16'h0101; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_iss");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        req1_op = 3'b100; req1_ab = 16'h0202; req1_valid = 1'b1;
        mid();
        check("rst_grant1", 32'({req1_ready, req0_ready}), 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_rsp");
        tick();
        rst_n = 1'b1;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        mid();
        check("rst_grant2", 32'({req1_ready, req0_ready}), 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("rst");
        check("cnt_rst", 32'(op_cnt), 1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("wrap_start", 32'(op_cnt), 0);
        g0 = gcnt;
        r0 = rcnt;
        rsp_ready = 1'b1;
        req0_op = 3'b001; req0_ab = 16'h0580; req0_valid = 1'b1;
        k = 0;
        while (gcnt < g0 + 256 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        #1;
        req0_valid = 1'b0;
        check("wrap_to", 32'(gcnt >= g0 + 256), 1);
        wait_idle("wrap");
        check("wrap_rsps", 32'(rcnt - r0), 256);
        check("wrap_cnt", 32'(op_cnt), 0);
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
